// File: rtl/vga_pkg.sv
// Shared timing defaults and FSM state encoding for the VGA timing receiver.
package vga_pkg;

  localparam int unsigned HTotalDef     = 800;
  localparam int unsigned VTotalDef     = 525;
  localparam int unsigned HVisibleDef   = 640;
  localparam int unsigned VVisibleDef   = 480;
  localparam int unsigned HSyncStartDef = 656;
  localparam int unsigned VSyncStartDef = 490;
  localparam int unsigned LockFramesDef = 2;

  typedef enum logic [1:0] {
    StSearch,
    StHAligned,
    StVerify,
    StLocked
  } state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Input register for one active-low sync plus a one-cycle falling-edge pulse.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic fall
);

  logic q;
  logic q_prev;

  // Syncs idle high, so both stages reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= 1'b1;
      q_prev <= 1'b1;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign fall = q_prev & ~q;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers x/y from syncs, locks after clean frames, counts sync errors.
// Optional per-frame colour checksum enabled by defining VGA_RX_CHECKSUM_EN.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL      = HTotalDef,
  parameter int unsigned V_TOTAL      = VTotalDef,
  parameter int unsigned H_VISIBLE    = HVisibleDef,
  parameter int unsigned V_VISIBLE    = VVisibleDef,
  parameter int unsigned H_SYNC_START = HSyncStartDef,
  parameter int unsigned V_SYNC_START = VSyncStartDef,
  parameter int unsigned LOCK_FRAMES  = LockFramesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  red_in,
  input  logic [2:0]  green_in,
  input  logic [2:0]  blue_in,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [2:0]  blue,
  output logic        pixel_valid,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [15:0] checksum,
  output logic        checksum_valid
);

  localparam logic [10:0] HLast       = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VLast       = 10'(V_TOTAL - 1);
  localparam logic [10:0] HSyncStart  = 11'(H_SYNC_START);
  localparam logic [9:0]  VSyncStart  = 10'(V_SYNC_START);
  localparam logic [10:0] HVis        = 11'(H_VISIBLE);
  localparam logic [9:0]  VVis        = 10'(V_VISIBLE);
  localparam logic [7:0]  LockFrames  = 8'(LOCK_FRAMES);
  // The edge is seen while hc labels the sync-start sample, so the reload is one pixel on.
  localparam logic [10:0] HLoad = (H_SYNC_START + 1 >= H_TOTAL) ? 11'd0 : 11'(H_SYNC_START + 1);

  logic        hs_fall, vs_fall;
  logic [8:0]  rgb_q;
  logic [10:0] hc, hc_d;
  logic [9:0]  vc, vc_d;
  logic [7:0]  clean_q, clean_d;
  state_e      state_q, state_d;
  logic        hs_err, vs_err, err, pv_d;

  vga_edge_det u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .d     (hsync_in),
    .fall  (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .d     (vsync_in),
    .fall  (vs_fall)
  );

  always_comb begin
    hs_err  = (state_q != StSearch) && (hs_fall != (hc == HSyncStart));
    vs_err  = ((state_q == StVerify) || (state_q == StLocked)) &&
              (vs_fall != ((hc == 11'd0) && (vc == VSyncStart)));
    err     = hs_err | vs_err;
    hc_d    = (hc == HLast) ? 11'd0 : hc + 11'd1;
    vc_d    = vc;
    if (hc == HLast) vc_d = (vc == VLast) ? 10'd0 : vc + 10'd1;
    state_d = state_q;
    clean_d = clean_q;
    if (err) begin
      state_d = StSearch;
    end else begin
      case (state_q)
        StSearch: begin
          if (hs_fall) begin
            hc_d    = HLoad;
            state_d = StHAligned;
          end
        end
        StHAligned: begin
          if (vs_fall && (hc == 11'd0)) begin
            vc_d    = VSyncStart;
            clean_d = 8'd0;
            state_d = StVerify;
          end
        end
        StVerify, StLocked: begin
          if (vs_fall) begin
            if (clean_q != 8'hFF) clean_d = clean_q + 8'd1;
            if ((state_q == StVerify) && (clean_d >= LockFrames)) state_d = StLocked;
          end
        end
        default: state_d = StSearch;
      endcase
    end
    pv_d = (state_d == StLocked) && (hc < HVis) && (vc < VVis);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      clean_q     <= 8'd0;
      hc          <= 11'd0;
      vc          <= 10'd0;
      rgb_q       <= 9'd0;
      x           <= 11'd0;
      y           <= 10'd0;
      red         <= 3'd0;
      green       <= 3'd0;
      blue        <= 3'd0;
      locked      <= 1'b0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_q              <= state_d;
      clean_q              <= clean_d;
      hc                   <= hc_d;
      vc                   <= vc_d;
      rgb_q                <= {red_in, green_in, blue_in};
      x                    <= hc;
      y                    <= vc;
      {red, green, blue}   <= rgb_q;
      locked               <= (state_d == StLocked);
      pixel_valid          <= pv_d;
      frame_start          <= pv_d && (hc == 11'd0) && (vc == 10'd0);
      sync_err             <= err;
      if (err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  localparam logic [10:0] HLastVis = 11'(H_VISIBLE - 1);
  localparam logic [9:0]  VLastVis = 10'(V_VISIBLE - 1);

  logic [15:0] acc_q;
  logic [15:0] pix;
  logic        frame_ok_q;
  logic        last_pix;

  assign pix      = {7'd0, red, green, blue};
  assign last_pix = pixel_valid && (x == HLastVis) && (y == VLastVis);

  // frame_ok_q drops on any loss of lock so a torn frame never reports a checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= 16'd0;
      frame_ok_q     <= 1'b0;
      checksum       <= 16'd0;
      checksum_valid <= 1'b0;
    end else begin
      checksum_valid <= 1'b0;
      if (frame_start)      acc_q <= pix;
      else if (pixel_valid) acc_q <= acc_q + pix;
      if (!locked)          frame_ok_q <= 1'b0;
      else if (frame_start) frame_ok_q <= 1'b1;
      if (last_pix && (frame_ok_q || frame_start)) begin
        checksum       <= (frame_start ? 16'd0 : acc_q) + pix;
        checksum_valid <= 1'b1;
      end
    end
  end
`else
  assign checksum       = 16'd0;
  assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a reduced 20x12 raster (12x8 visible).
module tb_vga_timing_rx;

  localparam int unsigned HT = 20;
  localparam int unsigned VT = 12;
  localparam int unsigned HV = 12;
  localparam int unsigned VV = 8;
  localparam int unsigned HS = 14;
  localparam int unsigned VS = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [2:0]  red_in = 3'd0, green_in = 3'd0, blue_in = 3'd0;
  logic [10:0] x;
  logic [9:0]  y;
  logic [2:0]  red, green, blue;
  logic        pixel_valid, locked, frame_start, sync_err, checksum_valid;
  logic [7:0]  err_count;
  logic [15:0] checksum;

  int errors = 0;
  int checks = 0;
  int sx = 0, sy = 0, px = 0, py = 0, ex = 0, ey = 0;
  logic [2:0] pr = 0, pg = 0, pb = 0, er = 0, eg = 0, eb = 0;
  int mode = 0;
  bit hshift = 0, vdrop = 0, toggle = 0;
  int pulses = 0, cv_seen = 0;

  vga_timing_rx #(
    .H_TOTAL      (HT),
    .V_TOTAL      (VT),
    .H_VISIBLE    (HV),
    .V_VISIBLE    (VV),
    .H_SYNC_START (HS),
    .V_SYNC_START (VS),
    .LOCK_FRAMES  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .red_in         (red_in),
    .green_in       (green_in),
    .blue_in        (blue_in),
    .x              (x),
    .y              (y),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .pixel_valid    (pixel_valid),
    .locked         (locked),
    .frame_start    (frame_start),
    .sync_err       (sync_err),
    .err_count      (err_count),
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one source pixel, clock it, and remember what the outputs should now show.
  task automatic step();
    logic [2:0] r, g, b;
    case (mode)
      1:       begin r = 3'h7; g = 3'h7; b = 3'h7; end
      2:       begin r = 3'd0; g = 3'd0; b = (sx == 0 && sy == 0) ? 3'd1 : 3'd0; end
      default: begin r = 3'(sx); g = 3'(sy); b = 3'(sx + sy); end
    endcase
    if (toggle)      hsync_in = ~hsync_in;
    else if (hshift) hsync_in = !(sx >= HS + 1 && sx < HS + 3);
    else             hsync_in = !(sx >= HS && sx < HS + 2);
    vsync_in = vdrop ? 1'b1 : !(sy == VS || sy == VS + 1);
    red_in = r; green_in = g; blue_in = b;
    @(posedge clk); #1;
    ex = px; ey = py; er = pr; eg = pg; eb = pb;
    px = sx; py = sy; pr = r; pg = g; pb = b;
    if (sync_err) pulses++;
    if (checksum_valid) cv_seen++;
    sx++;
    if (sx == HT) begin
      sx = 0;
      sy = (sy == VT - 1) ? 0 : sy + 1;
    end
  endtask

  task automatic run_to_top();
    for (int i = 0; i < 300 && !(sx == 0 && sy == 0); i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_rgb"}, 32'({red, green, blue}), 0);
    check({tag, "_pv"}, 32'(pixel_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_serr"}, 32'(sync_err), 0);
    check({tag, "_errcnt"}, 32'(err_count), 0);
    check({tag, "_csum"}, 32'(checksum), 0);
    check({tag, "_csv"}, 32'(checksum_valid), 0);
  endtask

  initial begin
    int n;
    int e0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Align at hsync pixel 14, vsync at pixel 180, clean edges at 420 and 660.
    n = 0;
    while (!locked && n < 2000) begin step(); n++; end
    check("lock_steps", 32'(n), 662);
    check("lock_errcnt", 32'(err_count), 0);
    check("lock_pulses", 32'(pulses), 0);

    n = 0;
    while (!frame_start && n < 1000) begin step(); n++; end
    check("fs_steps", 32'(n), 60);
    check("fs_x", 32'(x), 0);
    check("fs_y", 32'(y), 0);
    check("fs_pv", 32'(pixel_valid), 1);

    for (int i = 0; i < HT * VT; i++) begin
      step();
      check("scan_x", 32'(x), 32'(ex));
      check("scan_y", 32'(y), 32'(ey));
      check("scan_rgb", 32'({red, green, blue}), 32'({er, eg, eb}));
      check("scan_pv", 32'(pixel_valid), 32'(ex < HV && ey < VV));
      check("scan_fs", 32'(frame_start), 32'(ex == 0 && ey == 0));
      check("scan_locked", 32'(locked), 1);
    end

`ifdef VGA_RX_CHECKSUM_EN
    run_to_top();
    mode = 1;
    n = 0;
    cv_seen = 0;
    while (!checksum_valid && n < 500) begin step(); n++; end
    check("csum_ones", 32'(checksum), 32'h0000BFA0);
    run_to_top();
    mode = 2;
    n = 0;
    while (!checksum_valid && n < 500) begin step(); n++; end
    check("csum_single", 32'(checksum), 1);
    mode = 0;
`else
    check("csum_off", 32'(checksum), 0);
    check("csv_off", 32'(cv_seen), 0);
`endif

    // One line with the hsync pulse one pixel late.
    while (!(sx == 0 && sy == 2)) step();
    hshift = 1;
    n = 0;
    while (!sync_err && n < 40) begin step(); n++; end
    check("hshift_serr", 32'(sync_err), 1);
    check("hshift_locked", 32'(locked), 0);
    check("hshift_errcnt", 32'(err_count), 1);
    check("hshift_x", 32'(x), HS);
    check("hshift_y", 32'(y), 2);
    step();
    check("hshift_pulse_len", 32'(sync_err), 0);
    while (sx != 0) step();
    hshift = 0;
    n = 0;
    while (!locked && n < 2000) begin step(); n++; end
    check("hshift_relock", 32'(locked), 1);

    // One frame with its vsync pulse missing.
    run_to_top();
    vdrop = 1;
    e0 = int'(err_count);
    n = 0;
    while (!sync_err && n < 300) begin step(); n++; end
    check("vdrop_serr", 32'(sync_err), 1);
    check("vdrop_x", 32'(x), 0);
    check("vdrop_y", 32'(y), VS);
    check("vdrop_locked", 32'(locked), 0);
    check("vdrop_errcnt", 32'(err_count), 32'(e0 + 1));
    run_to_top();
    vdrop = 0;
    n = 0;
    while (!locked && n < 2000) begin step(); n++; end
    check("vdrop_relock", 32'(locked), 1);
    check("vdrop_errcnt_after", 32'(err_count), 32'(e0 + 1));

    // Reset mid-frame while locked, then relock from scratch.
    while (!(sx == 3 && sy == 5)) step();
    check("pre_reset_locked", 32'(locked), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    sx = 0;
    sy = 0;
    n = 0;
    while (!locked && n < 2000) begin step(); n++; end
    check("relock_steps", 32'(n), 662);

    // Hsync toggling every pixel: an error about every 4 cycles.
    toggle = 1;
    repeat (2000) step();
    check("sat_errcnt", 32'(err_count), 255);
    check("sat_locked", 32'(locked), 0);
    repeat (100) step();
    check("sat_hold", 32'(err_count), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
